// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vm_pkg
//  Function : Shared widths, coin terminator and FSM state encoding for the
//             coin-purchase sale sequencer.
//  Revision : 1.0
// ============================================================================
package vm_pkg;

    localparam int MW_PADRAO = 5;
    localparam int SW_PADRAO = 8;
    localparam int MOEDA_FIM = 0;
    localparam int EST_W     = 3;

    typedef enum logic [EST_W-1:0] {
        ST_IDLE    = 3'd0,
        ST_PEDE    = 3'd1,
        ST_SOLTA   = 3'd2,
        ST_SOMA    = 3'd3,
        ST_ENTREGA = 3'd4,
        ST_DEVOLVE = 3'd5
    } estado_t;

endpackage
`default_nettype wire

// File: rtl/conta_ciclos.sv
`default_nettype none
// ============================================================================
//  Module   : conta_ciclos
//  Function : Loadable down-counter; o_fim flags the last cycle of a phase.
//  Revision : 1.0
// ============================================================================
module conta_ciclos #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_carrega,
    input  logic [W-1:0] i_valor,
    output logic         o_fim
);

    logic [W-1:0] r_cont;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cont <= '0;
        end else if (i_carrega) begin
            r_cont <= i_valor;
        end else if (r_cont != '0) begin
            r_cont <= r_cont - W'(1);
        end
    end

    assign o_fim = (r_cont == '0);

endmodule
`default_nettype wire

// File: rtl/controle_venda.sv
`default_nettype none
// ============================================================================
//  Module   : controle_venda
//  Function : Sale sequencer: requests coins from the feeder, accumulates the
//             balance against the latched price and issues sale/refund pulses.
//  Revision : 1.0
// ============================================================================
module controle_venda
    import vm_pkg::*;
#(
    parameter int MW         = MW_PADRAO,
    parameter int SW         = SW_PADRAO,
    parameter int NEXT_HI    = 2,
    parameter int NEXT_LO    = 2,
    parameter int MAX_MOEDAS = 31
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          comprar,
    input  logic [SW-1:0] preco,
    input  logic          cancelar,
    input  logic [MW-1:0] moeda,
    output logic          next,
    output logic          vendeu,
    output logic [SW-1:0] troco,
    output logic          troco_ok,
    output logic [SW-1:0] saldo,
    output logic          ocupado,
    output logic          erro
);

    localparam int FASE_MAX = (NEXT_HI > NEXT_LO) ? NEXT_HI : NEXT_LO;
    localparam int CW       = $clog2(FASE_MAX);
    localparam int CNTW     = $clog2(MAX_MOEDAS + 1);

    estado_t         r_estado;
    estado_t         w_prox;
    logic [SW-1:0]   r_saldo;
    logic [SW-1:0]   r_preco;
    logic [SW-1:0]   r_troco;
    logic [CNTW-1:0] r_cont;
    logic            r_cancelado;

    logic            w_carrega;
    logic [CW-1:0]   w_valor;
    logic            w_fim_fase;
    logic [SW:0]     w_soma;
    logic            w_moeda_fim;
    logic            w_estouro;
    logic            w_pago;
    logic            w_limite;

    conta_ciclos #(
        .W (CW)
    ) u_conta (
        .clk       (clk),
        .reset     (reset),
        .i_carrega (w_carrega),
        .i_valor   (w_valor),
        .o_fim     (w_fim_fase)
    );

    // Sum is one bit wider so a carry out marks an unrepresentable balance.
    assign w_soma      = {1'b0, r_saldo} + (SW+1)'(moeda);
    assign w_moeda_fim = (moeda == MW'(MOEDA_FIM));
    assign w_estouro   = w_soma[SW];
    assign w_pago      = (w_soma[SW-1:0] >= r_preco);
    assign w_limite    = ((r_cont + CNTW'(1)) == CNTW'(MAX_MOEDAS));

    always_comb begin
        w_prox    = r_estado;
        w_carrega = 1'b0;
        w_valor   = CW'(NEXT_HI - 1);
        case (r_estado)
            ST_IDLE: begin
                if (comprar) begin
                    if (preco == '0) begin
                        w_prox = ST_ENTREGA;
                    end else begin
                        w_prox    = ST_PEDE;
                        w_carrega = 1'b1;
                    end
                end
            end
            ST_PEDE: begin
                if (cancelar) begin
                    w_prox = ST_DEVOLVE;
                end else if (w_fim_fase) begin
                    w_prox    = ST_SOLTA;
                    w_carrega = 1'b1;
                    w_valor   = CW'(NEXT_LO - 1);
                end
            end
            ST_SOLTA: begin
                if (cancelar) begin
                    w_prox = ST_DEVOLVE;
                end else if (w_fim_fase) begin
                    w_prox = ST_SOMA;
                end
            end
            ST_SOMA: begin
                if (cancelar || w_moeda_fim || w_estouro) begin
                    w_prox = ST_DEVOLVE;
                end else if (w_pago) begin
                    w_prox = ST_ENTREGA;
                end else if (w_limite) begin
                    w_prox = ST_DEVOLVE;
                end else begin
                    w_prox    = ST_PEDE;
                    w_carrega = 1'b1;
                end
            end
            ST_ENTREGA: w_prox = ST_IDLE;
            ST_DEVOLVE: w_prox = ST_IDLE;
            default:    w_prox = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_estado <= ST_IDLE;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_saldo     <= '0;
            r_preco     <= '0;
            r_troco     <= '0;
            r_cont      <= '0;
            r_cancelado <= 1'b0;
        end else begin
            case (r_estado)
                ST_IDLE: begin
                    if (comprar) begin
                        r_preco     <= preco;
                        r_saldo     <= '0;
                        r_cont      <= '0;
                        r_troco     <= '0;
                        r_cancelado <= 1'b0;
                    end
                end
                ST_PEDE, ST_SOLTA: begin
                    if (cancelar) begin
                        r_cancelado <= 1'b1;
                    end
                end
                ST_SOMA: begin
                    if (cancelar) begin
                        r_cancelado <= 1'b1;
                    end else if (!w_moeda_fim && !w_estouro) begin
                        r_saldo <= w_soma[SW-1:0];
                        r_cont  <= r_cont + CNTW'(1);
                    end
                end
                ST_ENTREGA: r_troco <= r_saldo - r_preco;
                ST_DEVOLVE: r_troco <= r_saldo;
                default: ;
            endcase
        end
    end

    // Change is driven straight from the balance during the pulse so it is
    // valid together with troco_ok, then held by r_troco.
    always_comb begin
        troco = r_troco;
        if (r_estado == ST_ENTREGA) begin
            troco = r_saldo - r_preco;
        end else if (r_estado == ST_DEVOLVE) begin
            troco = r_saldo;
        end
    end

    assign next     = (r_estado == ST_PEDE);
    assign vendeu   = (r_estado == ST_ENTREGA) || (r_estado == ST_DEVOLVE);
    assign troco_ok = vendeu;
    assign erro     = (r_estado == ST_DEVOLVE) && !r_cancelado;
    assign ocupado  = (r_estado != ST_IDLE);
    assign saldo    = r_saldo;

endmodule
`default_nettype wire

// File: tb/tb_controle_venda.sv
`default_nettype none
// ============================================================================
//  Module   : tb_controle_venda
//  Function : Self-checking bench for controle_venda with a coin-feeder model
//             and a per-sale schedule model of the expected outputs.
//  Revision : 1.0
// ============================================================================
module tb_controle_venda;

    localparam int MW      = 5;
    localparam int SW      = 8;
    localparam int NEXT_HI = 2;
    localparam int NEXT_LO = 2;
    localparam int MAXM    = 31;
    localparam int L       = NEXT_HI + NEXT_LO + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          comprar = 1'b0;
    logic          cancelar = 1'b0;
    logic [SW-1:0] preco = '0;
    logic [MW-1:0] moeda;
    logic          nxt;
    logic          vendeu;
    logic [SW-1:0] troco;
    logic          troco_ok;
    logic [SW-1:0] saldo;
    logic          ocupado;
    logic          erro;

    always #5 clk = ~clk;

    controle_venda #(
        .MW         (MW),
        .SW         (SW),
        .NEXT_HI    (NEXT_HI),
        .NEXT_LO    (NEXT_LO),
        .MAX_MOEDAS (MAXM)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .comprar  (comprar),
        .preco    (preco),
        .cancelar (cancelar),
        .moeda    (moeda),
        .next     (nxt),
        .vendeu   (vendeu),
        .troco    (troco),
        .troco_ok (troco_ok),
        .saldo    (saldo),
        .ocupado  (ocupado),
        .erro     (erro)
    );

    // Feeder: each rising next advances to the following coin; vendeu rewinds.
    int   feed [0:63];
    int   npulse = 0;
    logic next_q = 1'b0;

    always @(negedge clk) begin
        if (!reset || vendeu) npulse = 0;
        else if (nxt && !next_q) npulse = npulse + 1;
        next_q = nxt;
    end

    always_comb moeda = (npulse == 0) ? '0 : MW'(feed[npulse-1]);

    int endc, troco_e, erro_e;
    int exp_saldo [0:255];
    int t = 0;
    bit ativo = 0;
    bit chk_en = 0;
    int held_troco = 0, held_saldo = 0;
    int obs_end = -1, obs_troco = 0, obs_erro = 0;
    int n_checks = 0, n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s t=%0d actual=%0d expected=%0d", nm, t, act, exp_v);
        end
    endtask

    // Sale outcome from coin order: coin i is summed at relative cycle (i+1)*L.
    function automatic void model(input int p, input int cc);
        int  s;
        bit  done;
        s = 0; done = 0; endc = 0; troco_e = 0; erro_e = 0;
        for (int k = 0; k < 256; k++) exp_saldo[k] = 0;
        if (p == 0) begin
            endc = 1;
            done = 1;
        end
        for (int i = 0; i < MAXM && !done; i++) begin
            int ts;
            ts = (i + 1) * L;
            if (cc > i * L && cc <= ts) begin
                endc = cc + 1; troco_e = s; done = 1;
            end else if (feed[i] == 0 || s + feed[i] > 255) begin
                endc = ts + 1; troco_e = s; erro_e = 1; done = 1;
            end else begin
                s = s + feed[i];
                for (int k = ts + 1; k < 256; k++) exp_saldo[k] = s;
                if (s >= p) begin
                    endc = ts + 1; troco_e = s - p; done = 1;
                end else if (i + 1 == MAXM) begin
                    endc = ts + 1; troco_e = s; erro_e = 1; done = 1;
                end
            end
        end
    endfunction

    always @(negedge clk) begin
        int e_next, e_vend, e_erro, e_ocup, e_troco, e_saldo;
        if (chk_en) begin
            if (ativo) begin
                e_vend  = (t == endc) ? 1 : 0;
                e_next  = (t < endc && ((t - 1) % L) < NEXT_HI) ? 1 : 0;
                e_erro  = (e_vend == 1 && erro_e == 1) ? 1 : 0;
                e_ocup  = 1;
                e_troco = (e_vend == 1) ? troco_e : 0;
                e_saldo = exp_saldo[t];
            end else begin
                e_vend = 0; e_next = 0; e_erro = 0; e_ocup = 0;
                e_troco = held_troco; e_saldo = held_saldo;
            end
            chk("next", int'(nxt), e_next);
            chk("vendeu", int'(vendeu), e_vend);
            chk("troco_ok", int'(troco_ok), e_vend);
            chk("erro", int'(erro), e_erro);
            chk("ocupado", int'(ocupado), e_ocup);
            chk("troco", int'(troco), e_troco);
            chk("saldo", int'(saldo), e_saldo);
            if (ativo && vendeu) begin
                obs_end = t; obs_troco = int'(troco); obs_erro = int'(erro);
            end
        end
    end

    task automatic set_feed(input int v0, input int v1, input int n, input int rest);
        for (int k = 0; k < 64; k++) feed[k] = (k < n) ? rest : 0;
        if (v0 >= 0) feed[0] = v0;
        if (v1 >= 0) feed[1] = v1;
    endtask

    // Runs one sale; lit_end=-2 skips literal checks, -1 expects no vendeu.
    task automatic venda(input int p, input int cc, input int rc,
                         input int lit_end, input int lit_troco, input int lit_erro);
        bit fim;
        model(p, cc);
        comprar = 1'b1;
        preco   = SW'(p);
        @(posedge clk); #1;
        t = 1; ativo = 1; obs_end = -1; fim = 0;
        while (!fim && t <= endc) begin
            cancelar = (t == cc);
            reset    = (t == rc) ? 1'b0 : 1'b1;
            comprar  = 1'($urandom_range(0, 1));
            preco    = SW'($urandom);
            @(posedge clk); #1;
            if (t == rc) begin
                fim = 1; held_troco = 0; held_saldo = 0;
            end
            t++;
        end
        if (!fim) begin
            held_troco = troco_e;
            held_saldo = exp_saldo[endc];
        end
        ativo = 0; cancelar = 0; comprar = 0; reset = 1; preco = '0;
        if (lit_end != -2) chk("lit_fim", obs_end, lit_end);
        if (lit_end > 0) begin
            chk("lit_troco", obs_troco, lit_troco);
            chk("lit_erro", obs_erro, lit_erro);
        end
    endtask

    initial begin
        int p, cc;
        for (int k = 0; k < 64; k++) feed[k] = 0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1;
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        set_feed(5, 5, 0, 0);   venda(10, 0, 0, 11, 0, 0);
        set_feed(5, 5, 0, 0);   venda(7, 0, 0, 11, 3, 0);
        set_feed(5, 0, 0, 0);   venda(20, 0, 0, 11, 5, 1);
        set_feed(-1, -1, 40, 5); venda(50, 6, 0, 7, 5, 0);
        set_feed(-1, -1, 40, 25); venda(255, 0, 0, 56, 250, 1);
        venda(0, 0, 0, 1, 0, 0);
        set_feed(-1, -1, 40, 1); venda(200, 0, 0, 156, 31, 1);
        set_feed(-1, -1, 40, 5); venda(50, 0, 3, -1, 0, 0);
        chk("saldo_pos_reset", int'(saldo), 0);
        chk("next_pos_reset", int'(nxt), 0);
        @(posedge clk); #1;

        for (int n = 0; n < 25; n++) begin
            for (int k = 0; k < 64; k++) begin
                feed[k] = ($urandom_range(0, 99) < 4) ? 0 : int'($urandom_range(1, 31));
            end
            case ($urandom_range(0, 3))
                0:       p = int'($urandom_range(0, 40));
                1:       p = int'($urandom_range(200, 255));
                default: p = int'($urandom_range(0, 255));
            endcase
            cc = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 40)) : 0;
            venda(p, cc, 0, -2, 0, 0);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end

        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
